// File: rtl/bt_calc_sequencer.sv
// rtl/bt_calc_sequencer.sv - command sequencer for the balanced-ternary calculator ALU
// Optional illegal-trit rejection with sticky err: define BTCALC_TRITCHK_EN.
module bt_calc_sequencer #(
  parameter int ALU_WAIT = 1,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [3:0]       cmd_data,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic             alu_sel,
  input  logic [7:0]       alu_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic [CNT_W-1:0] op_count,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [1:0] OP_LOAD_A = 2'b00;
  localparam logic [1:0] OP_LOAD_B = 2'b01;
  localparam logic [1:0] OP_ADD    = 2'b10;
  localparam logic [3:0] WAIT_INIT = 4'(ALU_WAIT - 1);

  state_t     state;
  logic [3:0] wait_cnt;
  logic [3:0] a_reg;
  logic [3:0] b_reg;
  logic       cmd_fire;
  logic       load_ok;
  logic [3:0] load_val;

  function automatic logic has_illegal(input logic [3:0] d);
    return (d[3:2] == 2'b00) || (d[1:0] == 2'b00);
  endfunction

  function automatic logic [3:0] norm_trits(input logic [3:0] d);
    logic [3:0] n;
    n[3:2] = (d[3:2] == 2'b00) ? 2'b11 : d[3:2];
    n[1:0] = (d[1:0] == 2'b00) ? 2'b11 : d[1:0];
    return n;
  endfunction

  assign cmd_ready = (state == IDLE);
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign alu_a     = a_reg;
  assign alu_b     = b_reg;

`ifdef BTCALC_TRITCHK_EN
  logic err_q;

  assign load_ok  = !has_illegal(cmd_data);
  assign load_val = cmd_data;
  assign err      = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_q <= 1'b0;
    else if (cmd_fire && !cmd_op[1] && !load_ok)
      err_q <= 1'b1;
  end
`else
  assign load_ok  = 1'b1;
  assign load_val = norm_trits(cmd_data);
  assign err      = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      a_reg     <= 4'hF;
      b_reg     <= 4'hF;
      alu_sel   <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= 8'hFF;
      op_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            case (cmd_op)
              OP_LOAD_A: if (load_ok) a_reg <= load_val;
              OP_LOAD_B: if (load_ok) b_reg <= load_val;
              default: begin
                alu_sel  <= (cmd_op == OP_ADD);
                wait_cnt <= WAIT_INIT;
                state    <= EXEC;
              end
            endcase
          end
        end
        // Operands are frozen here, so the ALU sees stable inputs until capture.
        EXEC: begin
          if (wait_cnt == 4'd0) begin
            res_data  <= alu_result;
            res_valid <= 1'b1;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            op_count  <= op_count + 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bt_calc_sequencer.sv
// tb/tb_bt_calc_sequencer.sv - self-checking bench for bt_calc_sequencer (two parameterisations)
module tb_bt_calc_sequencer;

  localparam int WAIT0 = 1;
  localparam int WAIT1 = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid [2];
  logic       cmd_ready [2];
  logic [1:0] cmd_op    [2];
  logic [3:0] cmd_data  [2];
  logic [3:0] alu_a     [2];
  logic [3:0] alu_b     [2];
  logic       alu_sel   [2];
  logic [7:0] alu_result[2];
  logic       res_valid [2];
  logic       res_ready [2];
  logic [7:0] res_data  [2];
  logic       err       [2];
  logic       glitch    [2];
  logic [7:0] oc0;
  logic [1:0] oc1;

  logic [3:0] m_a   [2];
  logic [3:0] m_b   [2];
  int         m_cnt [2];
  logic       m_err [2];
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  function automatic int tdec(input logic [1:0] t);
    case (t)
      2'b10:   return 1;
      2'b01:   return -1;
      default: return 0;
    endcase
  endfunction

  function automatic int vdec(input logic [3:0] v);
    return 3 * tdec(v[3:2]) + tdec(v[1:0]);
  endfunction

  function automatic logic [7:0] enc4(input int v);
    logic [7:0] r;
    int m;
    for (int i = 0; i < 4; i++) begin
      m = ((v % 3) + 3) % 3;
      if (m == 0) begin r[2*i +: 2] = 2'b11; v = v / 3; end
      else if (m == 1) begin r[2*i +: 2] = 2'b10; v = (v - 1) / 3; end
      else begin r[2*i +: 2] = 2'b01; v = (v + 1) / 3; end
    end
    return r;
  endfunction

  function automatic logic [7:0] alu_model(input logic [3:0] a, input logic [3:0] b, input logic sel);
    return enc4(sel ? vdec(a) + vdec(b) : vdec(a) * vdec(b));
  endfunction

  assign alu_result[0] = glitch[0] ? 8'h00 : alu_model(alu_a[0], alu_b[0], alu_sel[0]);
  assign alu_result[1] = glitch[1] ? 8'h00 : alu_model(alu_a[1], alu_b[1], alu_sel[1]);

  bt_calc_sequencer #(.ALU_WAIT(WAIT0), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_op(cmd_op[0]), .cmd_data(cmd_data[0]),
    .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_sel(alu_sel[0]), .alu_result(alu_result[0]),
    .res_valid(res_valid[0]), .res_ready(res_ready[0]), .res_data(res_data[0]),
    .op_count(oc0), .err(err[0])
  );

  bt_calc_sequencer #(.ALU_WAIT(WAIT1), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_op(cmd_op[1]), .cmd_data(cmd_data[1]),
    .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_sel(alu_sel[1]), .alu_result(alu_result[1]),
    .res_valid(res_valid[1]), .res_ready(res_ready[1]), .res_data(res_data[1]),
    .op_count(oc1), .err(err[1])
  );

  function automatic logic [31:0] cnt_of(input int i);
    return (i == 0) ? {24'd0, oc0} : {30'd0, oc1};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_a[i] = 4'hF; m_b[i] = 4'hF; m_cnt[i] = 0; m_err[i] = 1'b0;
    end
  endtask

  task automatic model_load(input int i, input logic is_b, input logic [3:0] d);
    logic [3:0] nd;
    nd = d;
    if (d[3:2] == 2'b00 || d[1:0] == 2'b00) begin
`ifdef BTCALC_TRITCHK_EN
      m_err[i] = 1'b1;
      return;
`else
      if (d[3:2] == 2'b00) nd[3:2] = 2'b11;
      if (d[1:0] == 2'b00) nd[1:0] = 2'b11;
`endif
    end
    if (is_b) m_b[i] = nd;
    else      m_a[i] = nd;
  endtask

  task automatic check_regs(input int i);
    chk("alu_a", alu_a[i], m_a[i]);
    chk("alu_b", alu_b[i], m_b[i]);
    chk("err", err[i], m_err[i]);
  endtask

  task automatic send_cmd(input int i, input logic [1:0] op, input logic [3:0] d);
    int k;
    k = 0;
    cmd_valid[i] = 1'b1; cmd_op[i] = op; cmd_data[i] = d;
    while (!cmd_ready[i] && k < 50) begin tick(1); k++; end
    chk("cmd_ready_wait", k < 50, 1);
    tick(1);
    cmd_valid[i] = 1'b0;
    if (!op[1]) model_load(i, op[0], d);
  endtask

  task automatic do_op(input int i, input logic [1:0] op, input int hold, input bit early, input bit offer,
                       output logic [7:0] exp);
    int k;
    exp = enc4(op == 2'b10 ? vdec(m_a[i]) + vdec(m_b[i]) : vdec(m_a[i]) * vdec(m_b[i]));
    res_ready[i] = early;
    send_cmd(i, op, 4'($urandom));
    k = 0;
    while (!res_valid[i] && k < 40) begin
      chk("cmd_ready_exec", cmd_ready[i], 0);
      if (k == 2) glitch[i] = 1'b0;
      tick(1);
      k++;
    end
    chk("latency", k, (i == 0) ? WAIT0 : WAIT1);
    chk("alu_sel", alu_sel[i], op == 2'b10);
    chk("res_data", res_data[i], exp);
    if (!early) begin
      if (offer) begin
        cmd_valid[i] = 1'b1; cmd_op[i] = 2'b00; cmd_data[i] = ~m_a[i] | 4'h5;
      end
      repeat (hold) begin
        tick(1);
        chk("hold_valid", res_valid[i], 1);
        chk("hold_data", res_data[i], exp);
        chk("hold_cmd_ready", cmd_ready[i], 0);
        chk("hold_alu_a", alu_a[i], m_a[i]);
      end
      cmd_valid[i] = 1'b0;
    end
    res_ready[i] = 1'b1;
    tick(1);
    res_ready[i] = 1'b0;
    m_cnt[i]++;
    chk("res_valid_clr", res_valid[i], 0);
    chk("res_data_kept", res_data[i], exp);
    chk("op_count", cnt_of(i), m_cnt[i] % ((i == 0) ? 256 : 4));
    chk("cmd_ready_back", cmd_ready[i], 1);
    check_regs(i);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    int         seq [5];
    int         i;
    int         op;
    seq = '{1, 2, 3, 0, 1};
    for (int j = 0; j < 2; j++) begin
      cmd_valid[j] = 1'b0; cmd_op[j] = 2'b00; cmd_data[j] = 4'h0;
      res_ready[j] = 1'b0; glitch[j] = 1'b0;
    end
    model_reset();
    rst = 1'b1;
    tick(3);
    for (int j = 0; j < 2; j++) begin
      chk("rst_cmd_ready", cmd_ready[j], 1);
      chk("rst_res_valid", res_valid[j], 0);
      chk("rst_res_data", res_data[j], 8'hFF);
      chk("rst_op_count", cnt_of(j), 0);
      chk("rst_alu_sel", alu_sel[j], 0);
      check_regs(j);
    end
    @(negedge clk) rst = 1'b0;
    tick(1);

    // ADD 4+4 with ALU_WAIT=1, loads back-to-back
    send_cmd(0, 2'b00, 4'hA);
    chk("b2b_cmd_ready", cmd_ready[0], 1);
    send_cmd(0, 2'b01, 4'hA);
    check_regs(0);
    do_op(0, 2'b10, 0, 0, 0, r);
    chk("add_8", res_data[0], 8'hED);
    chk("add_count", cnt_of(0), 1);

    // MUL 4*4 with 5 cycles of backpressure and a LOAD_A offered meanwhile
    do_op(0, 2'b11, 5, 0, 1, r);
    chk("mul_16", res_data[0], 8'h96);
    chk("mul_alu_a", alu_a[0], 4'hA);

    // ALU_WAIT=4 latency; ALU output only settles at E+2
    send_cmd(1, 2'b00, 4'h9);
    send_cmd(1, 2'b01, 4'hE);
    glitch[1] = 1'b1;
    do_op(1, 2'b10, 1, 0, 0, r);
    chk("lat_add_3", res_data[1], enc4(3));

    // Asynchronous reset while in EXEC
    send_cmd(1, 2'b11, 4'h0);
    tick(1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("arst_res_valid", res_valid[1], 0);
    chk("arst_cmd_ready", cmd_ready[1], 1);
    chk("arst_res_data", res_data[1], 8'hFF);
    chk("arst_op_count", cnt_of(1), 0);
    check_regs(1);
    @(negedge clk) rst = 1'b0;
    tick(1);

    // Illegal trit in a LOAD
    send_cmd(0, 2'b00, 4'h2);
`ifdef BTCALC_TRITCHK_EN
    chk("illegal_a", alu_a[0], 4'hF);
    chk("illegal_err", err[0], 1);
`else
    chk("illegal_a", alu_a[0], 4'hE);
    chk("illegal_err", err[0], 0);
`endif
    send_cmd(0, 2'b01, 4'h6);
    do_op(0, 2'b10, 0, 0, 0, r);

    // Counter wrap on the 2-bit instance, loads in between
    for (int j = 0; j < 5; j++) begin
      send_cmd(1, 2'($urandom_range(0, 1)), 4'($urandom));
      do_op(1, 2'($urandom_range(2, 3)), 0, 1'($urandom), 0, r);
      chk("wrap_seq", cnt_of(1), seq[j]);
    end

    // Randomised command mix on both instances
    for (int j = 0; j < 60; j++) begin
      i  = $urandom_range(0, 1);
      op = $urandom_range(0, 3);
      if (op < 2) begin
        send_cmd(i, 2'(op), 4'($urandom));
        check_regs(i);
      end else begin
        do_op(i, 2'(op), $urandom_range(0, 3), 1'($urandom), 1'($urandom), r);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
